mem_req_gen: RTL and testbench
==============================

Name: mem_req_gen

Overview:
- Transmit-side counterpart of the memory controller's three source channels (sdram, flash, rom).
- Accepts 4-bit host requests tagged with a target channel and holds one pending word per channel.
- Serializes each word into the two-beat valid framing the controller's per-channel receive FSMs expect; channels run independently and concurrently.
- Exports the same fuzzing-coverage outputs as the controller (toggle bits, state-tuple coverage sum, meta_reset).

Parameters:
- DROP_W, 4, width of the saturating counter of requests dropped for an invalid target.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- meta_reset  in  1  clears coverage map/sum only
- req_valid  in  1  host request valid
- req_target  in  2  0=sdram, 1=flash, 2=rom, 3=invalid
- req_data  in  4  word to send
- req_ready  out  1  request accepted when req_valid && req_ready
- sdram_ready  in  1  receiver ready
- sdram_valid  out  1  beat valid
- sdram_data_o  out  2  beat data
- flash_ready  in  1
- flash_valid  out  1
- flash_data_o  out  4
- rom_ready  in  1
- rom_valid  out  1
- rom_data_o  out  1
- drop_count  out  DROP_W  saturating count of target-3 requests
- coverage  out  9  sticky toggle bits
- io_cov_sum  out  6  distinct state tuples seen

Behaviour:
- Clock is clock; reset is synchronous and active-high; no asynchronous reset anywhere.
- Reset clears all channel FSMs to IDLE, all buffers to empty, all data registers to 0, and drop_count to 0. All *_valid and *_data_o are 0 in the cycle after reset is sampled. reset mid-frame aborts the frame immediately and discards any buffered word.
- req_ready = !buf_full[req_target]; forced to 1 when req_target==3.
- A target-3 request is accepted and discarded; drop_count increments and saturates at all-ones.
- Each channel has a one-entry buffer (buf_full, buf_data) plus a frame register (frm_data).
- Per-channel FSM states: IDLE -> BEAT0 -> BEAT1 -> GAP -> IDLE.
  - IDLE -> BEAT0 when buf_full && ch_ready are sampled high; on that edge buf_data moves to frm_data and buf_full clears.
  - BEAT0 -> BEAT1, BEAT1 -> GAP, and GAP -> IDLE are unconditional; a frame is never aborted except by reset.
  - ch_ready is ignored outside IDLE. GAP covers the receiver's BUSY cycle, during which its ready is low.
- ch_valid = (state==BEAT0 || state==BEAT1), decoded from state registers only.
- Beat data:
  - sdram: frm[1:0] in BEAT0, frm[3:2] in BEAT1.
  - flash: frm[3:0] in both beats.
  - rom: frm[0] in BEAT0, frm[1] in BEAT1; frm[3:2] are not transmitted.
- Data outputs are 0 whenever the corresponding valid is 0.
- Latency: request accepted at edge N with ready high → valid in cycles N+1 and N+2, GAP at N+3, IDLE at N+4. Minimum frame period per channel is 4 cycles.
- A new request for a channel may be accepted in the cycle its buffer empties (BEAT0 onward); the buffered word waits for IDLE.
- Accepting a request and the buffer being consumed never happen on the same edge for one channel; req_ready is low while the buffer is full.
- Coverage:
  - reg_state = {fsm_flash, fsm_sdram, fsm_rom} (2 bits each), registered each cycle.
  - A 64-entry covmap: on the first sighting of a value, set its bit and increment io_cov_sum.
  - meta_reset clears covmap and io_cov_sum; reset does not clear them.
  - Toggle inputs: per channel, (state==IDLE), (state==BEAT0), ch_ready.
  - coverage = {sdram×3, flash×3, rom×3}, each bit from its own sticky toggle detector.

Decomposition:
- Shared package holds:
  - target encodings TGT_SDRAM=0, TGT_FLASH=1, TGT_ROM=2, TGT_INV=3;
  - FSM encodings IDLE=0, BEAT0=1, BEAT1=2, GAP=3.
- One generic per-channel sub-module, mem_tx_chan: buffer, frame register, FSM, valid, frm_data out. It is instantiated three times; beat slicing is done in the top level.
- The existing saturating_counter module is reused for toggle coverage.

Test Plan:
- Reset, then sdram request data=4'hB, sdram_ready=1 → sdram_valid high 2 cycles; sdram_data_o=2'b11 then 2'b10; low in GAP; req_ready back high the cycle after acceptance.
- Flash request 4'h6 with flash_ready=0 for 5 cycles, then 1 → no valid while ready=0; valid for exactly 2 cycles starting 1 cycle after ready rises; flash_data_o=4'h6 both beats.
- Rom request 4'hE → rom_data_o=0 then 1; two back-to-back rom requests 4'h1, 4'h2 → second accepted during the first frame; frames start 4 cycles apart.
- All three channels requested on consecutive cycles with ready=1 → valid windows overlap; io_cov_sum increments for each new state tuple; meta_reset → io_cov_sum=0.
- 20 requests with target=3 and DROP_W=4 → req_ready=1 throughout; no channel valid; drop_count saturates at 15.
- reset asserted during BEAT1 with a buffered word → all valid=0 the next cycle; no frame afterwards; req_ready=1.

Source files
------------

// File: rtl/mem_req_gen_pkg.sv
// Shared encodings for the memory request generator: target channel codes,
// per-channel transmit FSM states and the coverage tuple packing helper.
package mem_req_gen_pkg;

    // Host request target encodings.
    typedef enum logic [1:0] {
        TGT_SDRAM = 2'd0,
        TGT_FLASH = 2'd1,
        TGT_ROM   = 2'd2,
        TGT_INV   = 2'd3
    } tgt_e;

    // Per-channel transmit FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        GAP   = 2'd3
    } chan_state_e;

    localparam int WORD_W    = 4;
    localparam int COV_W     = 9;
    localparam int COV_SUM_W = 6;
    localparam int TUPLE_W   = 6;
    localparam int COVMAP_N  = 1 << TUPLE_W;

    // Packs the three channel states into the coverage tuple {flash, sdram, rom}.
    function automatic logic [TUPLE_W-1:0] state_tuple(input chan_state_e st_flash,
                                                      input chan_state_e st_sdram,
                                                      input chan_state_e st_rom);
        return {st_flash, st_sdram, st_rom};
    endfunction

endpackage

// File: rtl/mem_req_gen_if.sv
// Host request bus plus the three per-channel two-beat transmit links.
// master = host/receiver side, slave = the request generator.
interface mem_req_gen_if;
    logic       req_valid;
    logic [1:0] req_target;
    logic [3:0] req_data;
    logic       req_ready;

    logic       sdram_ready;
    logic       sdram_valid;
    logic [1:0] sdram_data_o;

    logic       flash_ready;
    logic       flash_valid;
    logic [3:0] flash_data_o;

    logic       rom_ready;
    logic       rom_valid;
    logic       rom_data_o;

    modport master (
        output req_valid, req_target, req_data,
        input  req_ready,
        output sdram_ready, flash_ready, rom_ready,
        input  sdram_valid, sdram_data_o,
        input  flash_valid, flash_data_o,
        input  rom_valid, rom_data_o
    );

    modport slave (
        input  req_valid, req_target, req_data,
        output req_ready,
        input  sdram_ready, flash_ready, rom_ready,
        output sdram_valid, sdram_data_o,
        output flash_valid, flash_data_o,
        output rom_valid, rom_data_o
    );
endinterface

// File: rtl/mem_req_gen_tx_chan.sv
// One transmit channel: one-entry word buffer, frame register and the
// IDLE -> BEAT0 -> BEAT1 -> GAP framing FSM. Beat slicing is left to the top.
module mem_tx_chan
    import mem_req_gen_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en_i,
    input  logic [WORD_W-1:0] wr_data_i,
    input  logic              ch_ready_i,
    output logic              buf_full_o,
    output chan_state_e       state_o,
    output logic              valid_o,
    output logic [WORD_W-1:0] frm_data_o
);

    chan_state_e       state_q;
    logic              buf_full_q;
    logic [WORD_W-1:0] buf_data_q;
    logic [WORD_W-1:0] frm_data_q;

    // Buffer fill and framing FSM; a started frame always runs to GAP,
    // only reset aborts it. Fill only happens when empty and launch only
    // when full, so both never hit the same edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            buf_full_q <= 1'b0;
            buf_data_q <= '0;
            frm_data_q <= '0;
        end else begin
            if (wr_en_i) begin
                buf_full_q <= 1'b1;
                buf_data_q <= wr_data_i;
            end
            case (state_q)
                IDLE: begin
                    if (buf_full_q && ch_ready_i) begin
                        state_q    <= BEAT0;
                        frm_data_q <= buf_data_q;
                        buf_full_q <= 1'b0;
                    end
                end
                BEAT0:   state_q <= BEAT1;
                BEAT1:   state_q <= GAP;
                GAP:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign buf_full_o = buf_full_q;
    assign state_o    = state_q;
    assign valid_o    = (state_q == BEAT0) || (state_q == BEAT1);
    assign frm_data_o = frm_data_q;

endmodule

// File: rtl/saturating_counter.sv
// Up-counter that sticks at all-ones; with WIDTH=1 it is a sticky hit flag.
module saturating_counter #(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;

    // Count increments until all-ones, clear has priority.
    always_ff @(posedge clock) begin
        if (clr_i) begin
            count_q <= '0;
        end else if (inc_i && (count_q != {WIDTH{1'b1}})) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/mem_req_gen.sv
// Memory request generator top: routes host requests to the sdram, flash and
// rom transmit channels, slices frames into beats, counts dropped requests and
// produces toggle and state-tuple coverage.
module mem_req_gen
    import mem_req_gen_pkg::*;
#(
    parameter int DROP_W = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 meta_reset,
    mem_req_gen_if.slave         bus,
    output logic [DROP_W-1:0]    drop_count,
    output logic [COV_W-1:0]     coverage,
    output logic [COV_SUM_W-1:0] io_cov_sum
);

    tgt_e              tgt;
    logic              accept;
    logic              wr_sdram, wr_flash, wr_rom;
    logic              drop_inc;

    logic              full_sdram, full_flash, full_rom;
    chan_state_e       st_sdram, st_flash, st_rom;
    logic              vld_sdram, vld_flash, vld_rom;
    logic [WORD_W-1:0] frm_sdram, frm_flash, frm_rom;

    assign tgt = tgt_e'(bus.req_target);

    // Ready reflects the addressed buffer; invalid targets are always taken.
    always_comb begin
        bus.req_ready = 1'b1;
        case (tgt)
            TGT_SDRAM: bus.req_ready = !full_sdram;
            TGT_FLASH: bus.req_ready = !full_flash;
            TGT_ROM:   bus.req_ready = !full_rom;
            default:   bus.req_ready = 1'b1;
        endcase
    end

    assign accept   = bus.req_valid && bus.req_ready;
    assign wr_sdram = accept && (tgt == TGT_SDRAM);
    assign wr_flash = accept && (tgt == TGT_FLASH);
    assign wr_rom   = accept && (tgt == TGT_ROM);
    assign drop_inc = accept && (tgt == TGT_INV);

    mem_tx_chan u_sdram (
        .clock      (clock),
        .reset      (reset),
        .wr_en_i    (wr_sdram),
        .wr_data_i  (bus.req_data),
        .ch_ready_i (bus.sdram_ready),
        .buf_full_o (full_sdram),
        .state_o    (st_sdram),
        .valid_o    (vld_sdram),
        .frm_data_o (frm_sdram)
    );

    mem_tx_chan u_flash (
        .clock      (clock),
        .reset      (reset),
        .wr_en_i    (wr_flash),
        .wr_data_i  (bus.req_data),
        .ch_ready_i (bus.flash_ready),
        .buf_full_o (full_flash),
        .state_o    (st_flash),
        .valid_o    (vld_flash),
        .frm_data_o (frm_flash)
    );

    mem_tx_chan u_rom (
        .clock      (clock),
        .reset      (reset),
        .wr_en_i    (wr_rom),
        .wr_data_i  (bus.req_data),
        .ch_ready_i (bus.rom_ready),
        .buf_full_o (full_rom),
        .state_o    (st_rom),
        .valid_o    (vld_rom),
        .frm_data_o (frm_rom)
    );

    assign bus.sdram_valid = vld_sdram;
    assign bus.flash_valid = vld_flash;
    assign bus.rom_valid   = vld_rom;

    // Beat slicing: sdram sends low then high pair, flash repeats the word,
    // rom sends bit0 then bit1; data is forced to zero outside valid beats.
    always_comb begin
        bus.sdram_data_o = 2'b00;
        bus.flash_data_o = 4'h0;
        bus.rom_data_o   = 1'b0;
        case (st_sdram)
            BEAT0:   bus.sdram_data_o = frm_sdram[1:0];
            BEAT1:   bus.sdram_data_o = frm_sdram[3:2];
            default: bus.sdram_data_o = 2'b00;
        endcase
        if (vld_flash) begin
            bus.flash_data_o = frm_flash;
        end
        case (st_rom)
            BEAT0:   bus.rom_data_o = frm_rom[0];
            BEAT1:   bus.rom_data_o = frm_rom[1];
            default: bus.rom_data_o = 1'b0;
        endcase
    end

    saturating_counter #(.WIDTH(DROP_W)) u_drop_cnt (
        .clock   (clock),
        .clr_i   (reset),
        .inc_i   (drop_inc),
        .count_o (drop_count)
    );

    // Toggle coverage: each probe has a sticky detector cleared by meta_reset.
    logic [COV_W-1:0] tog_in;
    logic [COV_W-1:0] tog_prev_q;

    assign tog_in = {(st_sdram == IDLE), (st_sdram == BEAT0), bus.sdram_ready,
                     (st_flash == IDLE), (st_flash == BEAT0), bus.flash_ready,
                     (st_rom == IDLE),   (st_rom == BEAT0),   bus.rom_ready};

    // Previous-cycle probe values for edge detection.
    always_ff @(posedge clock) begin
        tog_prev_q <= tog_in;
    end

    for (genvar gi = 0; gi < COV_W; gi++) begin : g_tog
        saturating_counter #(.WIDTH(1)) u_tog (
            .clock   (clock),
            .clr_i   (meta_reset),
            .inc_i   (tog_in[gi] ^ tog_prev_q[gi]),
            .count_o (coverage[gi])
        );
    end

    // State-tuple coverage: only meta_reset clears the map and the sum.
    logic [TUPLE_W-1:0]   reg_state_q;
    logic [COVMAP_N-1:0]  covmap_q,  covmap_d;
    logic [COV_SUM_W-1:0] cov_sum_q, cov_sum_d;

    // Next map and sum when the registered tuple is seen for the first time.
    always_comb begin
        covmap_d  = covmap_q;
        cov_sum_d = cov_sum_q;
        if (!covmap_q[reg_state_q]) begin
            covmap_d[reg_state_q] = 1'b1;
            if (cov_sum_q != {COV_SUM_W{1'b1}}) begin
                cov_sum_d = cov_sum_q + COV_SUM_W'(1);
            end
        end
    end

    // Tuple sampling every cycle, map/sum update with meta_reset priority.
    always_ff @(posedge clock) begin
        reg_state_q <= state_tuple(st_flash, st_sdram, st_rom);
        if (meta_reset) begin
            covmap_q  <= '0;
            cov_sum_q <= '0;
        end else begin
            covmap_q  <= covmap_d;
            cov_sum_q <= cov_sum_d;
        end
    end

    assign io_cov_sum = cov_sum_q;

endmodule

// File: tb/tb_mem_req_gen.sv
// Directed bench for mem_req_gen: inputs change and outputs are sampled 1ns
// after each rising edge.
module tb_mem_req_gen;

    logic       clock = 1'b0;
    logic       reset;
    logic       meta_reset;
    logic [3:0] drop_count;
    logic [8:0] coverage;
    logic [5:0] io_cov_sum;

    int n_chk  = 0;
    int n_fail = 0;

    mem_req_gen_if bus ();

    mem_req_gen #(.DROP_W(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .meta_reset (meta_reset),
        .bus        (bus),
        .drop_count (drop_count),
        .coverage   (coverage),
        .io_cov_sum (io_cov_sum)
    );

    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic v, input logic [1:0] t, input logic [3:0] d);
        bus.req_valid  = v;
        bus.req_target = t;
        bus.req_data   = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        meta_reset = 1'b1;
        req(1'b0, 2'd0, 4'h0);
        bus.sdram_ready = 1'b0;
        bus.flash_ready = 1'b0;
        bus.rom_ready   = 1'b0;
        tick(3);
        chk("rst_valids", {bus.sdram_valid, bus.flash_valid, bus.rom_valid}, 3'b000);
        chk("rst_data", {bus.sdram_data_o, bus.flash_data_o, bus.rom_data_o}, 7'h00);
        chk("rst_drop", drop_count, 4'd0);
        chk("rst_covsum", io_cov_sum, 6'd0);
        chk("rst_coverage", coverage, 9'h000);
        chk("rst_ready", bus.req_ready, 1'b1);
        reset = 1'b0;
        meta_reset = 1'b0;
        tick(3);
        chk("idle_covsum", io_cov_sum, 6'd1);

        // sdram frame, word 4'hB
        bus.sdram_ready = 1'b1;
        req(1'b1, 2'd0, 4'hB);
        tick(1);
        chk("sd_ready_full", bus.req_ready, 1'b0);
        chk("sd_v_acc", bus.sdram_valid, 1'b0);
        bus.req_valid = 1'b0;
        tick(1);
        chk("sd_v_b0", bus.sdram_valid, 1'b1);
        chk("sd_d_b0", bus.sdram_data_o, 2'b11);
        chk("sd_ready_back", bus.req_ready, 1'b1);
        tick(1);
        chk("sd_v_b1", bus.sdram_valid, 1'b1);
        chk("sd_d_b1", bus.sdram_data_o, 2'b10);
        tick(1);
        chk("sd_v_gap", bus.sdram_valid, 1'b0);
        chk("sd_d_gap", bus.sdram_data_o, 2'b00);
        tick(1);
        chk("sd_v_idle", bus.sdram_valid, 1'b0);
        tick(3);
        chk("sd_covsum", io_cov_sum, 6'd4);
        chk("sd_coverage", coverage, 9'h1C0);

        // flash frame, word 4'h6, receiver not ready for 5 cycles
        req(1'b1, 2'd1, 4'h6);
        tick(1);
        bus.req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("fl_hold", bus.flash_valid, 1'b0);
            tick(1);
        end
        bus.flash_ready = 1'b1;
        tick(1);
        chk("fl_v_b0", bus.flash_valid, 1'b1);
        chk("fl_d_b0", bus.flash_data_o, 4'h6);
        tick(1);
        chk("fl_v_b1", bus.flash_valid, 1'b1);
        chk("fl_d_b1", bus.flash_data_o, 4'h6);
        tick(1);
        chk("fl_v_gap", bus.flash_valid, 1'b0);
        chk("fl_d_gap", bus.flash_data_o, 4'h0);
        tick(4);
        chk("fl_covsum", io_cov_sum, 6'd7);
        chk("fl_coverage", coverage, 9'h1F8);

        // rom frame, word 4'hE
        bus.rom_ready = 1'b1;
        req(1'b1, 2'd2, 4'hE);
        tick(1);
        bus.req_valid = 1'b0;
        chk("rm_v_acc", bus.rom_valid, 1'b0);
        tick(1);
        chk("rm_v_b0", bus.rom_valid, 1'b1);
        chk("rm_d_b0", bus.rom_data_o, 1'b0);
        tick(1);
        chk("rm_v_b1", bus.rom_valid, 1'b1);
        chk("rm_d_b1", bus.rom_data_o, 1'b1);
        tick(1);
        chk("rm_v_gap", bus.rom_valid, 1'b0);
        tick(3);

        // back-to-back rom words 4'h1 then 4'h2
        req(1'b1, 2'd2, 4'h1);
        tick(1);
        req(1'b1, 2'd2, 4'h2);
        chk("bb_ready_full", bus.req_ready, 1'b0);
        tick(1);
        chk("bb1_v_b0", bus.rom_valid, 1'b1);
        chk("bb1_d_b0", bus.rom_data_o, 1'b1);
        chk("bb_ready_free", bus.req_ready, 1'b1);
        tick(1);
        chk("bb_ready_refull", bus.req_ready, 1'b0);
        chk("bb1_d_b1", bus.rom_data_o, 1'b0);
        bus.req_valid = 1'b0;
        tick(1);
        chk("bb1_v_gap", bus.rom_valid, 1'b0);
        tick(1);
        chk("bb_v_idle", bus.rom_valid, 1'b0);
        tick(1);
        chk("bb2_v_b0", bus.rom_valid, 1'b1);
        chk("bb2_d_b0", bus.rom_data_o, 1'b0);
        tick(1);
        chk("bb2_v_b1", bus.rom_valid, 1'b1);
        chk("bb2_d_b1", bus.rom_data_o, 1'b1);
        tick(1);
        chk("bb2_v_gap", bus.rom_valid, 1'b0);
        tick(4);
        chk("rm_covsum", io_cov_sum, 6'd10);
        chk("rm_coverage", coverage, 9'h1FF);

        // three channels on consecutive cycles
        req(1'b1, 2'd0, 4'hF);
        tick(1);
        req(1'b1, 2'd1, 4'hA);
        tick(1);
        req(1'b1, 2'd2, 4'h3);
        tick(1);
        bus.req_valid = 1'b0;
        chk("cc_sd_fl_v", {bus.sdram_valid, bus.flash_valid, bus.rom_valid}, 3'b110);
        chk("cc_sd_d", bus.sdram_data_o, 2'b11);
        chk("cc_fl_d", bus.flash_data_o, 4'hA);
        tick(1);
        chk("cc_fl_rm_v", {bus.sdram_valid, bus.flash_valid, bus.rom_valid}, 3'b011);
        chk("cc_rm_d", bus.rom_data_o, 1'b1);
        tick(6);
        chk("cc_covsum", io_cov_sum, 6'd13);
        meta_reset = 1'b1;
        tick(1);
        chk("meta_covsum", io_cov_sum, 6'd0);
        chk("meta_coverage", coverage, 9'h000);
        meta_reset = 1'b0;
        tick(3);
        chk("meta_covsum_after", io_cov_sum, 6'd1);

        // invalid-target requests
        for (int i = 0; i < 20; i++) begin
            req(1'b1, 2'd3, 4'(i));
            #1;
            chk("inv_ready", bus.req_ready, 1'b1);
            tick(1);
            chk("inv_no_valid", {bus.sdram_valid, bus.flash_valid, bus.rom_valid}, 3'b000);
            if (i == 4) chk("drop_5", drop_count, 4'd5);
        end
        bus.req_valid = 1'b0;
        chk("drop_sat", drop_count, 4'd15);

        // reset during BEAT1 with a word buffered
        req(1'b1, 2'd0, 4'h5);
        tick(1);
        req(1'b1, 2'd0, 4'h9);
        tick(1);
        chk("ra_v_b0", bus.sdram_valid, 1'b1);
        tick(1);
        chk("ra_v_b1", bus.sdram_valid, 1'b1);
        chk("ra_d_b1", bus.sdram_data_o, 2'b01);
        chk("ra_ready_full", bus.req_ready, 1'b0);
        bus.req_valid = 1'b0;
        reset = 1'b1;
        tick(1);
        chk("ra_valids", {bus.sdram_valid, bus.flash_valid, bus.rom_valid}, 3'b000);
        chk("ra_data", {bus.sdram_data_o, bus.flash_data_o, bus.rom_data_o}, 7'h00);
        chk("ra_ready", bus.req_ready, 1'b1);
        chk("ra_drop", drop_count, 4'd0);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            chk("ra_no_frame", bus.sdram_valid, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
